// File: rtl/dot11_tx_bit_framer_pkg.sv
// dot11_tx_bit_framer_pkg
// Shared definitions for the legacy OFDM bit framer. The RX deframer imports the
// same package, so encodings and field widths must stay in step on both sides.
//   state_t        framer state encoding
//   RATE_*         4-bit legacy rate codes {R1,R2,R3,R4}
//   *_BITS         SIGNAL / SERVICE / TAIL field widths
//   n_dbps_of()    data bits per OFDM symbol for a rate code
//   signal_field() 24-bit SIGNAL word, bit 0 transmitted first
package dot11_tx_bit_framer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_SIGNAL  = 3'd2,
        S_SERVICE = 3'd3,
        S_PSDU    = 3'd4,
        S_TAIL    = 3'd5,
        S_PAD     = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [3:0] RATE_6M  = 4'hD;
    localparam logic [3:0] RATE_9M  = 4'hF;
    localparam logic [3:0] RATE_12M = 4'h5;
    localparam logic [3:0] RATE_18M = 4'h7;
    localparam logic [3:0] RATE_24M = 4'h9;
    localparam logic [3:0] RATE_36M = 4'hB;
    localparam logic [3:0] RATE_48M = 4'h1;
    localparam logic [3:0] RATE_54M = 4'h3;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;
    localparam int SCR_W        = 7;

    function automatic logic [7:0] n_dbps_of(input logic [3:0] rate);
        logic [7:0] n;
        case (rate)
            RATE_6M:  n = 8'd24;
            RATE_9M:  n = 8'd36;
            RATE_12M: n = 8'd48;
            RATE_18M: n = 8'd72;
            RATE_24M: n = 8'd96;
            RATE_36M: n = 8'd144;
            RATE_48M: n = 8'd192;
            RATE_54M: n = 8'd216;
            default:  n = 8'd24;
        endcase
        return n;
    endfunction

    // Bit order on air: R1..R4, reserved, LENGTH[0..11], parity, 6 tail zeros.
    function automatic logic [23:0] signal_field(input logic [3:0] rate, input logic [11:0] len);
        logic [16:0] head;
        head = {len, 1'b0, rate[0], rate[1], rate[2], rate[3]};
        return {6'b0, ^head, head};
    endfunction

endpackage

// File: rtl/dot11_tx_scrambler.sv
// dot11_tx_scrambler
// Frame-synchronous scrambler, polynomial x^7 + x^4 + 1.
//   clock, reset   clock and synchronous active-high reset (state cleared)
//   load           load_state into the shift register (wins over enable)
//   load_state     initial scrambler state
//   enable         advance one bit
//   bit_in/bit_out data in, scrambled data out (combinational from current state)
module dot11_tx_scrambler
    import dot11_tx_bit_framer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [SCR_W-1:0] load_state,
    input  logic             enable,
    input  logic             bit_in,
    output logic             bit_out
);

    logic [SCR_W-1:0] s;
    logic             fb;

    assign fb      = s[6] ^ s[3];
    assign bit_out = bit_in ^ fb;

    always_ff @(posedge clock) begin
        if (reset) begin
            s <= '0;
        end else if (load) begin
            s <= load_state;
        end else if (enable) begin
            s <= {s[5:0], fb};
        end
    end

endmodule

// File: rtl/dot11_tx_bit_framer.sv
// dot11_tx_bit_framer
// Turns one PSDU into the serial bit stream feeding the convolutional encoder:
// SIGNAL (unscrambled), then SERVICE, PSDU, TAIL and PAD through the scrambler.
//   clock, reset                 single clock, synchronous active-high reset
//   start, abort                 frame request (samples rate/psdu_len/seed), abandon
//   rate, psdu_len, seed         packet parameters
//   byte_in/_valid/_ready        PSDU byte stream in
//   bit_out/_valid/_ready        coded-bit-input stream out
//   bit_out_is_signal            current bit belongs to SIGNAL
//   n_ofdm_sym, n_bit_in_last_sym, phy_len_valid   PHY length info
//   busy, done, err              status; done and err are single-cycle pulses
//
// state     | meaning
// S_IDLE    | waiting for start; bad parameters raise err
// S_CALC    | repeated subtraction giving symbol count and last-symbol fill
// S_SIGNAL  | 24 SIGNAL bits, unscrambled
// S_SERVICE | 16 scrambled zeros
// S_PSDU    | PSDU bytes, LSB first, scrambled
// S_TAIL    | 6 zeros, scrambler still advances
// S_PAD     | scrambled zeros up to a whole number of symbols
// S_DONE    | one-cycle done pulse
module dot11_tx_bit_framer
    import dot11_tx_bit_framer_pkg::*;
#(
    parameter logic [6:0] SCRAMBLER_SEED_DEFAULT = 7'h5D
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  rate,
    input  logic [11:0] psdu_len,
    input  logic [6:0]  seed,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic        bit_out,
    output logic        bit_out_valid,
    input  logic        bit_out_ready,
    output logic        bit_out_is_signal,
    output logic [14:0] n_ofdm_sym,
    output logic [9:0]  n_bit_in_last_sym,
    output logic        phy_len_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state, state_nxt;

    logic [3:0]  rate_q;
    logic [11:0] len_q;
    logic [6:0]  seed_q;
    logic [7:0]  n_dbps_q;
    logic [15:0] calc_rem;
    logic [14:0] calc_cnt;
    logic [23:0] signal_sr;
    logic [4:0]  seg_cnt;
    logic [7:0]  byte_q;
    logic        byte_full;
    logic [2:0]  bit_idx;
    logic [11:0] bytes_left;
    logic [7:0]  sym_bit_cnt;
    logic [14:0] sym_cnt;
    logic        err_q;
    logic        phy_len_valid_q;
    logic [14:0] n_ofdm_sym_q;
    logic [9:0]  n_bit_last_q;

    logic        start_ok;
    logic        xfer;
    logic        data_xfer;
    logic        calc_last;
    logic        seg_last;
    logic        sym_wrap;
    logic        sym_last;
    logic        scr_load;
    logic        scr_in;
    logic        scr_out;

    assign start_ok  = start && rate[0] && (psdu_len != 12'd0);
    assign xfer      = bit_out_valid && bit_out_ready;
    assign data_xfer = xfer && (state == S_SERVICE || state == S_PSDU ||
                                state == S_TAIL    || state == S_PAD);
    // The remainder never reaches 0 here, so the final value lies in 1..N_DBPS
    // and already is the fill of the last symbol.
    assign calc_last = calc_rem <= {8'd0, n_dbps_q};
    assign seg_last  = seg_cnt == 5'd1;
    assign sym_wrap  = sym_bit_cnt == (n_dbps_q - 8'd1);
    assign sym_last  = sym_wrap && (sym_cnt == (n_ofdm_sym_q - 15'd1));
    assign scr_load  = (state == S_SIGNAL) && xfer && seg_last;
    assign scr_in    = (state == S_PSDU) ? byte_q[bit_idx] : 1'b0;

    dot11_tx_scrambler u_scrambler (
        .clock      (clock),
        .reset      (reset),
        .load       (scr_load),
        .load_state (seed_q),
        .enable     (data_xfer),
        .bit_in     (scr_in),
        .bit_out    (scr_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_CALC;
            S_CALC:    if (calc_last) state_nxt = S_SIGNAL;
            S_SIGNAL:  if (xfer && seg_last) state_nxt = S_SERVICE;
            S_SERVICE: if (xfer && seg_last) state_nxt = S_PSDU;
            S_PSDU:    if (xfer && bit_idx == 3'd7 && bytes_left == 12'd1) state_nxt = S_TAIL;
            S_TAIL:    if (xfer && seg_last) state_nxt = sym_last ? S_DONE : S_PAD;
            S_PAD:     if (xfer && sym_last) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        bit_out           = 1'b0;
        bit_out_valid     = 1'b0;
        bit_out_is_signal = 1'b0;
        byte_in_ready     = 1'b0;
        case (state)
            S_SIGNAL: begin
                bit_out_valid     = 1'b1;
                bit_out_is_signal = 1'b1;
                bit_out           = signal_sr[0];
            end
            S_SERVICE, S_PAD: begin
                bit_out_valid = 1'b1;
                bit_out       = scr_out;
            end
            S_PSDU: begin
                byte_in_ready = !byte_full;
                bit_out_valid = byte_full;
                bit_out       = scr_out;
            end
            S_TAIL: begin
                bit_out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rate_q          <= '0;
            len_q           <= '0;
            seed_q          <= '0;
            n_dbps_q        <= '0;
            calc_rem        <= '0;
            calc_cnt        <= '0;
            signal_sr       <= '0;
            seg_cnt         <= '0;
            byte_q          <= '0;
            byte_full       <= 1'b0;
            bit_idx         <= '0;
            bytes_left      <= '0;
            sym_bit_cnt     <= '0;
            sym_cnt         <= '0;
            err_q           <= 1'b0;
            phy_len_valid_q <= 1'b0;
            n_ofdm_sym_q    <= '0;
            n_bit_last_q    <= '0;
        end else if (abort) begin
            err_q           <= 1'b0;
            byte_full       <= 1'b0;
            phy_len_valid_q <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !start_ok;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        rate_q      <= rate;
                        len_q       <= psdu_len;
                        seed_q      <= (seed == 7'd0) ? SCRAMBLER_SEED_DEFAULT : seed;
                        n_dbps_q    <= n_dbps_of(rate);
                        calc_rem    <= 16'd22 + {1'b0, psdu_len, 3'b000};
                        calc_cnt    <= '0;
                        sym_bit_cnt <= '0;
                        sym_cnt     <= '0;
                        byte_full   <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (calc_last) begin
                        n_ofdm_sym_q    <= calc_cnt + 15'd1;
                        n_bit_last_q    <= calc_rem[9:0];
                        phy_len_valid_q <= 1'b1;
                        signal_sr       <= signal_field(rate_q, len_q);
                        seg_cnt         <= 5'(SIGNAL_BITS);
                    end else begin
                        calc_rem <= calc_rem - {8'd0, n_dbps_q};
                        calc_cnt <= calc_cnt + 15'd1;
                    end
                end
                S_SIGNAL: begin
                    if (xfer) begin
                        signal_sr <= signal_sr >> 1;
                        seg_cnt   <= seg_last ? 5'(SERVICE_BITS) : seg_cnt - 5'd1;
                    end
                end
                S_SERVICE: begin
                    if (xfer) begin
                        seg_cnt <= seg_cnt - 5'd1;
                        if (seg_last) begin
                            bytes_left <= len_q;
                            byte_full  <= 1'b0;
                        end
                    end
                end
                S_PSDU: begin
                    if (byte_in_valid && !byte_full) begin
                        byte_q    <= byte_in;
                        byte_full <= 1'b1;
                        bit_idx   <= '0;
                    end
                    if (xfer) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            byte_full  <= 1'b0;
                            bytes_left <= bytes_left - 12'd1;
                            seg_cnt    <= 5'(TAIL_BITS);
                        end
                    end
                end
                S_TAIL: begin
                    if (xfer) begin
                        seg_cnt <= seg_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    phy_len_valid_q <= 1'b0;
                end
                default: ;
            endcase
            if (data_xfer) begin
                sym_bit_cnt <= sym_wrap ? 8'd0 : sym_bit_cnt + 8'd1;
                if (sym_wrap) begin
                    sym_cnt <= sym_cnt + 15'd1;
                end
            end
        end
    end

    assign n_ofdm_sym        = n_ofdm_sym_q;
    assign n_bit_in_last_sym = n_bit_last_q;
    assign phy_len_valid     = phy_len_valid_q;
    assign busy              = state != S_IDLE;
    assign done              = state == S_DONE;
    assign err               = err_q;

endmodule

// File: tb/tb_dot11_tx_bit_framer.sv
// tb_dot11_tx_bit_framer
// Directed bench for dot11_tx_bit_framer: fixed packets with hand-derived length
// figures and SIGNAL/SERVICE patterns, plus a bit-serial reference stream.
module tb_dot11_tx_bit_framer;

    logic        clock = 1'b0;
    logic        reset, start, abort;
    logic [3:0]  rate;
    logic [11:0] psdu_len;
    logic [6:0]  seed;
    logic [7:0]  byte_in;
    logic        byte_in_valid, byte_in_ready;
    logic        bit_out, bit_out_valid, bit_out_ready, bit_out_is_signal;
    logic [14:0] n_ofdm_sym;
    logic [9:0]  n_bit_in_last_sym;
    logic        phy_len_valid, busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] psdu_mem [0:4095];
    bit  got_bits[$];
    bit  got_sig[$];
    bit  exp_bits[$];
    bit  saved_bits[$];
    int  done_cnt;
    bit  timed_out, plen_unstable;
    logic [14:0] got_nsym;
    logic [9:0]  got_nlast;
    logic post_busy, post_valid, post_ready, post_plen;
    logic [14:0] post_nsym;

    always #5 clock = ~clock;

    dot11_tx_bit_framer dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .rate              (rate),
        .psdu_len          (psdu_len),
        .seed              (seed),
        .byte_in           (byte_in),
        .byte_in_valid     (byte_in_valid),
        .byte_in_ready     (byte_in_ready),
        .bit_out           (bit_out),
        .bit_out_valid     (bit_out_valid),
        .bit_out_ready     (bit_out_ready),
        .bit_out_is_signal (bit_out_is_signal),
        .n_ofdm_sym        (n_ofdm_sym),
        .n_bit_in_last_sym (n_bit_in_last_sym),
        .phy_len_valid     (phy_len_valid),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    function automatic int ref_ndbps(input logic [3:0] r);
        case (r)
            4'hD: return 24;
            4'hF: return 36;
            4'h5: return 48;
            4'h7: return 72;
            4'h9: return 96;
            4'hB: return 144;
            4'h1: return 192;
            4'h3: return 216;
            default: return 24;
        endcase
    endfunction

    // Reference stream straight from the frame definition.
    task automatic build_expected(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd);
        int total, nd, nsym;
        logic [6:0] s;
        logic p, fb;
        exp_bits.delete();
        nd    = ref_ndbps(r);
        total = 22 + 8 * int'(l);
        nsym  = (total + nd - 1) / nd;
        p = 1'b0;
        for (int i = 3; i >= 0; i--) begin exp_bits.push_back(r[i]); p ^= r[i]; end
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 12; i++) begin exp_bits.push_back(l[i]); p ^= l[i]; end
        exp_bits.push_back(p);
        for (int i = 0; i < 6; i++) exp_bits.push_back(1'b0);
        s = (sd == 7'd0) ? 7'h5D : sd;
        for (int i = 0; i < nsym * nd; i++) begin
            fb = s[6] ^ s[3];
            s  = {s[5:0], fb};
            if (i >= 16 && i < 16 + 8 * int'(l))
                exp_bits.push_back(psdu_mem[(i - 16) / 8][(i - 16) % 8] ^ fb);
            else if (i >= total - 6 && i < total)
                exp_bits.push_back(1'b0);
            else
                exp_bits.push_back(fb);
        end
    endtask

    // First index where captured bits or SIGNAL flags disagree, -1 if identical.
    function automatic int first_diff();
        int n;
        n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
        for (int i = 0; i < n; i++)
            if (got_bits[i] !== exp_bits[i] || got_sig[i] !== (i < 24)) return i;
        if (got_bits.size() != exp_bits.size()) return n;
        return -1;
    endfunction

    task automatic run_packet(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd,
                              input bit stall, input int kill_at_byte, input bit kill_with_reset,
                              input int restart_at);
        int  byte_idx, after_kill, after_done, budget;
        bit  killed, done_seen, finished, plen_seen;
        got_bits.delete(); got_sig.delete();
        done_cnt = 0; plen_unstable = 0; timed_out = 0; plen_seen = 0;
        got_nsym = '0; got_nlast = '0;
        byte_idx = 0; after_kill = 0; after_done = 0;
        killed = 0; done_seen = 0; finished = 0;
        budget = 3000 + 10 * int'(l);
        @(negedge clock);
        rate = r; psdu_len = l; seed = sd; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc == restart_at) begin
                start = 1'b1; rate = 4'hD; psdu_len = 12'd7; seed = 7'h11;
            end else begin
                start = 1'b0;
            end
            if (killed) begin abort = 1'b0; reset = 1'b0; end
            bit_out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            byte_in_valid = !killed && (byte_idx < int'(l)) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            byte_in = psdu_mem[byte_idx];
            #1;
            if (killed) begin
                if (after_kill == 0) begin
                    post_busy = busy; post_valid = bit_out_valid; post_ready = byte_in_ready;
                    post_plen = phy_len_valid; post_nsym = n_ofdm_sym;
                end
                if (done) done_cnt++;
                after_kill++;
                if (after_kill == 8) begin finished = 1; break; end
            end else begin
                if (bit_out_valid && bit_out_ready) begin
                    got_bits.push_back(bit_out);
                    got_sig.push_back(bit_out_is_signal);
                end
                if (byte_in_valid && byte_in_ready) byte_idx++;
                if (phy_len_valid) begin
                    if (!plen_seen) begin
                        plen_seen = 1; got_nsym = n_ofdm_sym; got_nlast = n_bit_in_last_sym;
                    end else if (n_ofdm_sym !== got_nsym || n_bit_in_last_sym !== got_nlast) begin
                        plen_unstable = 1;
                    end
                end
                if (done_seen) begin
                    after_done++;
                    if (after_done == 3) begin post_busy = busy; post_plen = phy_len_valid; finished = 1; break; end
                end
                if (done) begin done_cnt++; done_seen = 1; end
                if (kill_at_byte >= 0 && byte_idx == kill_at_byte) begin
                    if (kill_with_reset) reset = 1'b1; else abort = 1'b1;
                    killed = 1;
                end
            end
            @(negedge clock);
        end
        if (!finished) begin
            timed_out = 1;
            @(negedge clock); abort = 1'b1;
            @(negedge clock); abort = 1'b0;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        byte_in_valid = 1'b0; bit_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        rate = 4'hD; psdu_len = 12'd1; seed = 7'h7F;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if ({busy, done, err, bit_out_valid, byte_in_ready, phy_len_valid, bit_out, bit_out_is_signal} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 00000000",
                     {busy, done, err, bit_out_valid, byte_in_ready, phy_len_valid, bit_out, bit_out_is_signal});
        end
        vectors++;
        if (n_ofdm_sym !== 15'd0) begin miscompares++; $display("FAIL reset_nsym: got %0d, expected 0", n_ofdm_sym); end
        vectors++;
        if (n_bit_in_last_sym !== 10'd0) begin miscompares++; $display("FAIL reset_nlast: got %0d, expected 0", n_bit_in_last_sym); end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_6m_len1();
        logic [23:0] sig_got;
        int d;
        psdu_mem[0] = 8'hA5;
        build_expected(4'hD, 12'd1, 7'h7F);
        run_packet(4'hD, 12'd1, 7'h7F, 0, -1, 0, -1);
        sig_got = '0;
        for (int i = 0; i < 24 && i < got_bits.size(); i++) sig_got[23 - i] = got_bits[i];
        vectors++;
        if (timed_out !== 1'b0) begin miscompares++; $display("FAIL 6m_timeout: got %0d, expected 0", timed_out); end
        vectors++;
        if (got_nsym !== 15'd2) begin miscompares++; $display("FAIL 6m_nsym: got %0d, expected 2", got_nsym); end
        vectors++;
        if (got_nlast !== 10'd6) begin miscompares++; $display("FAIL 6m_nlast: got %0d, expected 6", got_nlast); end
        vectors++;
        if (sig_got !== 24'b1101_0100_0000_0000_0000_0000) begin
            miscompares++; $display("FAIL 6m_signal: got %b, expected 110101000000000000000000", sig_got);
        end
        vectors++;
        if (got_bits.size() - 24 != 48) begin miscompares++; $display("FAIL 6m_data_bits: got %0d, expected 48", got_bits.size() - 24); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL 6m_done: got %0d pulses, expected 1", done_cnt); end
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL 6m_stream: first difference at bit %0d, expected none", d); end
        vectors++;
        if (post_busy !== 1'b0 || post_plen !== 1'b0) begin
            miscompares++; $display("FAIL 6m_idle_after: got busy=%b plen=%b, expected 0 0", post_busy, post_plen);
        end
    endtask

    task automatic test_54m_len100();
        int d;
        for (int i = 0; i < 100; i++) psdu_mem[i] = 8'(i * 7 + 3);
        build_expected(4'h3, 12'd100, 7'h2A);
        run_packet(4'h3, 12'd100, 7'h2A, 0, -1, 0, 5);
        vectors++;
        if (got_nsym !== 15'd4) begin miscompares++; $display("FAIL 54m_nsym: got %0d, expected 4", got_nsym); end
        vectors++;
        if (got_nlast !== 10'd174) begin miscompares++; $display("FAIL 54m_nlast: got %0d, expected 174", got_nlast); end
        vectors++;
        if (got_bits.size() - 24 != 864) begin miscompares++; $display("FAIL 54m_data_bits: got %0d, expected 864", got_bits.size() - 24); end
        vectors++;
        if (plen_unstable !== 1'b0) begin miscompares++; $display("FAIL 54m_len_stable: got %0d, expected 0", plen_unstable); end
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL 54m_stream: first difference at bit %0d, expected none", d); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL 54m_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    task automatic test_service_seed();
        logic [15:0] svc;
        logic [5:0]  tail;
        int d;
        for (int i = 0; i < 4; i++) psdu_mem[i] = 8'h00;
        build_expected(4'h5, 12'd4, 7'h7F);
        run_packet(4'h5, 12'd4, 7'h7F, 0, -1, 0, -1);
        svc = '1; tail = '1;
        for (int i = 0; i < 16; i++) if (24 + i < got_bits.size()) svc[15 - i] = got_bits[24 + i];
        for (int i = 0; i < 6; i++) if (72 + i < got_bits.size()) tail[5 - i] = got_bits[72 + i];
        vectors++;
        if (svc !== 16'b0000_1110_1111_0010) begin miscompares++; $display("FAIL service_bits: got %b, expected 0000111011110010", svc); end
        vectors++;
        if (tail !== 6'b0) begin miscompares++; $display("FAIL tail_bits: got %b, expected 000000", tail); end
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL service_stream: first difference at bit %0d, expected none", d); end
    endtask

    task automatic test_bad_start(input logic [3:0] r, input logic [11:0] l, input bit with_abort, input int exp_err);
        int err_hi, busy_hi, valid_hi;
        err_hi = 0; busy_hi = 0; valid_hi = 0;
        @(negedge clock);
        rate = r; psdu_len = l; seed = 7'h00; start = 1'b1; abort = with_abort;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start = 1'b0; abort = 1'b0;
            #1;
            if (err) err_hi++;
            if (busy) busy_hi++;
            if (bit_out_valid) valid_hi++;
        end
        vectors++;
        if (err_hi != exp_err) begin miscompares++; $display("FAIL bad_start_err r=%h l=%0d: got %0d cycles, expected %0d", r, l, err_hi, exp_err); end
        vectors++;
        if (busy_hi != 0 || valid_hi != 0) begin
            miscompares++; $display("FAIL bad_start_idle r=%h l=%0d: got busy %0d valid %0d cycles, expected 0 0", r, l, busy_hi, valid_hi);
        end
    endtask

    task automatic test_backpressure();
        int d;
        bit same;
        for (int i = 0; i < 20; i++) psdu_mem[i] = 8'($urandom_range(0, 255));
        build_expected(4'hB, 12'd20, 7'h00);
        run_packet(4'hB, 12'd20, 7'h00, 0, -1, 0, -1);
        saved_bits = got_bits;
        run_packet(4'hB, 12'd20, 7'h00, 1, -1, 0, -1);
        same = (saved_bits.size() == got_bits.size());
        for (int i = 0; same && i < got_bits.size(); i++) if (saved_bits[i] !== got_bits[i]) same = 0;
        vectors++;
        if (!same) begin miscompares++; $display("FAIL stall_vs_nostall: got %0d bits differing run, expected identical %0d bits", got_bits.size(), saved_bits.size()); end
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL stall_stream_default_seed: first difference at bit %0d, expected none", d); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL stall_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    task automatic test_kill(input bit with_reset);
        int d;
        for (int i = 0; i < 20; i++) psdu_mem[i] = 8'(255 - i * 11);
        run_packet(4'h9, 12'd20, 7'h33, 0, 5, with_reset, -1);
        vectors++;
        if (post_busy !== 1'b0 || post_valid !== 1'b0 || post_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_idle rst=%0d: got busy=%b valid=%b ready=%b, expected 0 0 0", with_reset, post_busy, post_valid, post_ready);
        end
        vectors++;
        if (done_cnt != 0) begin miscompares++; $display("FAIL kill_no_done rst=%0d: got %0d pulses, expected 0", with_reset, done_cnt); end
        vectors++;
        if (post_plen !== 1'b0) begin miscompares++; $display("FAIL kill_plen rst=%0d: got %b, expected 0", with_reset, post_plen); end
        if (with_reset) begin
            vectors++;
            if (post_nsym !== 15'd0) begin miscompares++; $display("FAIL reset_mid_nsym: got %0d, expected 0", post_nsym); end
        end
        for (int i = 0; i < 3; i++) psdu_mem[i] = 8'(8'h3C + i);
        build_expected(4'h7, 12'd3, 7'h01);
        run_packet(4'h7, 12'd3, 7'h01, 0, -1, 0, -1);
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL after_kill_stream rst=%0d: first difference at bit %0d, expected none", with_reset, d); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL after_kill_done rst=%0d: got %0d pulses, expected 1", with_reset, done_cnt); end
    endtask

    task automatic test_max_len();
        int d;
        for (int i = 0; i < 4095; i++) psdu_mem[i] = 8'($urandom_range(0, 255));
        build_expected(4'hD, 12'd4095, 7'h5A);
        run_packet(4'hD, 12'd4095, 7'h5A, 0, -1, 0, -1);
        vectors++;
        if (got_nsym !== 15'd1366) begin miscompares++; $display("FAIL max_nsym: got %0d, expected 1366", got_nsym); end
        vectors++;
        if (got_nlast !== 10'd22) begin miscompares++; $display("FAIL max_nlast: got %0d, expected 22", got_nlast); end
        d = first_diff();
        vectors++;
        if (d != -1) begin miscompares++; $display("FAIL max_stream: first difference at bit %0d, expected none", d); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL max_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        rate = 4'h0; psdu_len = 12'd0; seed = 7'd0;
        byte_in = 8'd0; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) psdu_mem[i] = 8'd0;
        test_reset();
        test_6m_len1();
        test_54m_len100();
        test_service_seed();
        test_bad_start(4'h4, 12'd10, 0, 1);
        test_bad_start(4'hD, 12'd0, 0, 1);
        test_bad_start(4'hD, 12'd10, 1, 0);
        test_backpressure();
        test_kill(0);
        test_kill(1);
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
